// File: rtl/mem_port_ctrl_pkg.sv
// rtl/mem_port_ctrl_pkg.sv - shared types and stall patterns for the memory port controller
package mem_port_ctrl_pkg;

   typedef enum logic [1:0] {
      MPC_IDLE = 2'd0,
      MPC_IF   = 2'd1,
      MPC_MEM  = 2'd2,
      MPC_DONE = 2'd3
   } mpc_state_t;

   // Bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb; each stage freezes everything upstream of it.
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/mem_port_ctrl_stall_merge.sv
// rtl/mem_port_ctrl_stall_merge.sv - priority merge of pipeline stall sources
// The deepest stalled stage wins so ex_mem never sees the bubble pattern for a MEM-side wait.
module mem_port_ctrl_stall_merge
   import mem_port_ctrl_pkg::*;
(
   input  logic       mem_pend,
   input  logic       ex_req,
   input  logic       id_req,
   input  logic       if_pend,
   output logic [5:0] stall
);

   always_comb begin
      stall = STALL_NONE;
      if (mem_pend)
         stall = STALL_MEM;
      else if (ex_req)
         stall = STALL_EX;
      else if (id_req)
         stall = STALL_ID;
      else if (if_pend)
         stall = STALL_IF;
   end

endmodule

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - arbitrates IF and MEM onto one external bus and builds the stall vector
// MEM wins on a tie; a granted transaction always runs to ack or timeout before the next grant.
module mem_port_ctrl
   import mem_port_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_sel,
   output logic [31:0] mem_rdata,
   output logic        mem_done,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   output logic [5:0]  stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_sel,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_err
);

   mpc_state_t       state;
   mpc_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             owner_mem;
   logic             aborted;
   logic             timeout_hit;

   assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= MPC_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MPC_IDLE: begin
            if (mem_req)
               state_nxt = MPC_MEM;
            else if (if_req)
               state_nxt = MPC_IF;
         end
         MPC_IF, MPC_MEM: begin
            if (bus_ack || timeout_hit)
               state_nxt = MPC_DONE;
         end
         default: state_nxt = MPC_IDLE;
      endcase
   end

   // Outputs decode straight from the state register, so reset clears them without a clock.
   always_comb begin
      bus_req  = (state == MPC_IF) || (state == MPC_MEM);
      if_done  = (state == MPC_DONE) && !owner_mem;
      mem_done = (state == MPC_DONE) && owner_mem;
      bus_err  = (state == MPC_DONE) && aborted;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_wdata <= 32'h0;
         bus_sel   <= 4'h0;
         if_rdata  <= 32'h0;
         mem_rdata <= 32'h0;
         cnt       <= '0;
         owner_mem <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         case (state)
            MPC_IDLE: begin
               cnt     <= '0;
               aborted <= 1'b0;
               if (mem_req) begin
                  owner_mem <= 1'b1;
                  bus_we    <= mem_we;
                  bus_addr  <= mem_addr;
                  bus_wdata <= mem_wdata;
                  bus_sel   <= mem_sel;
               end else if (if_req) begin
                  owner_mem <= 1'b0;
                  bus_we    <= 1'b0;
                  bus_addr  <= if_addr;
                  bus_wdata <= 32'h0;
                  bus_sel   <= 4'hF;
               end
            end
            MPC_IF, MPC_MEM: begin
               // An ack on the final timeout cycle still completes normally.
               if (bus_ack) begin
                  cnt <= '0;
                  if (owner_mem)
                     mem_rdata <= bus_rdata;
                  else
                     if_rdata <= bus_rdata;
               end else if (timeout_hit) begin
                  cnt     <= '0;
                  aborted <= 1'b1;
                  if (owner_mem)
                     mem_rdata <= 32'h0;
                  else
                     if_rdata <= 32'h0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   mem_port_ctrl_stall_merge u_stall_merge (
      .mem_pend (mem_req && !mem_done),
      .ex_req   (stallreq_ex),
      .id_req   (stallreq_id),
      .if_pend  (if_req && !if_done),
      .stall    (stall)
   );

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - scoreboard bench for mem_port_ctrl
module tb_mem_port_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [3:0]  mem_sel = 4'h0;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        stallreq_id = 1'b0;
   logic        stallreq_ex = 1'b0;
   logic [5:0]  stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_sel;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_err;

   typedef struct {
      logic        is_mem;
      logic [31:0] rdata;
   } done_t;

   done_t       done_q[$];
   logic [31:0] addr_q[$];
   logic        prev_bus_req = 1'b0;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   mem_port_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stall(stall),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   // Scoreboard monitor: grant order on bus_req rise, owner and data on each done pulse.
   always @(negedge clk) begin : monitor
      done_t       e;
      logic [31:0] a;
      logic [31:0] rd;
      if (!rst && (if_done || mem_done)) begin
         n_vec++;
         if (done_q.size() == 0) begin
            n_err++;
            $display("FAIL done_unexpected: if_done=%b mem_done=%b, required no pulse", if_done, mem_done);
         end else begin
            e  = done_q.pop_front();
            rd = mem_done ? mem_rdata : if_rdata;
            if (mem_done !== e.is_mem || if_done !== !e.is_mem || rd !== e.rdata) begin
               n_err++;
               $display("FAIL done_data: mem_done=%b if_done=%b rdata=%h, required mem=%b rdata=%h",
                        mem_done, if_done, rd, e.is_mem, e.rdata);
            end
         end
      end
      if (!rst && bus_req && !prev_bus_req) begin
         n_vec++;
         if (addr_q.size() == 0) begin
            n_err++;
            $display("FAIL bus_unexpected: bus_addr=%h, required no request", bus_addr);
         end else begin
            a = addr_q.pop_front();
            if (bus_addr !== a) begin
               n_err++;
               $display("FAIL bus_order: bus_addr=%h, required %h", bus_addr, a);
            end
         end
      end
      prev_bus_req <= bus_req;
   end

   task automatic serve(input int delay, input logic [31:0] rd, input logic [5:0] exp_stall);
      int          n;
      logic [31:0] a0, w0;
      logic [3:0]  s0;
      logic        we0;
      n = 0;
      while (bus_req !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      n_vec++;
      if (bus_req !== 1'b1) begin
         n_err++;
         $display("FAIL serve_bus_req: bus_req=%b after %0d cycles, required 1", bus_req, n);
         return;
      end
      a0 = bus_addr; w0 = bus_wdata; s0 = bus_sel; we0 = bus_we;
      for (int i = 0; i < delay; i++) begin
         n_vec++;
         if (bus_req !== 1'b1 || bus_addr !== a0 || bus_wdata !== w0 || bus_sel !== s0 ||
             bus_we !== we0 || stall !== exp_stall) begin
            n_err++;
            $display("FAIL serve_hold cyc%0d: req=%b addr=%h wdata=%h sel=%h we=%b stall=%b, required req=1 addr=%h wdata=%h sel=%h we=%b stall=%b",
                     i, bus_req, bus_addr, bus_wdata, bus_sel, bus_we, stall, a0, w0, s0, we0, exp_stall);
         end
         if (i == delay - 1) begin
            bus_ack   = 1'b1;
            bus_rdata = rd;
         end
         @(negedge clk);
      end
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++;
      if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel} !== 70'h0) begin
         n_err++;
         $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h sel=%h, required all 0",
                  bus_req, bus_we, bus_addr, bus_wdata, bus_sel);
      end
      n_vec++;
      if ({if_done, mem_done, bus_err} !== 3'b000 || if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_outs: if_done=%b mem_done=%b bus_err=%b if_rdata=%h mem_rdata=%h, required 0",
                  if_done, mem_done, bus_err, if_rdata, mem_rdata);
      end
      n_vec++;
      if (stall !== 6'b000000) begin
         n_err++;
         $display("FAIL reset_stall: stall=%b, required 000000", stall);
      end
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h100;
      addr_q.push_back(32'h100);
      done_q.push_back('{1'b0, 32'hDEADBEEF});
      #1;
      n_vec++;
      if (stall !== 6'b000011) begin
         n_err++;
         $display("FAIL fetch_stall_req: stall=%b, required 000011", stall);
      end
      serve(2, 32'hDEADBEEF, 6'b000011);
      n_vec++;
      if (if_done !== 1'b1 || if_rdata !== 32'hDEADBEEF || stall !== 6'b000000 || bus_req !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_done: if_done=%b if_rdata=%h stall=%b bus_req=%b, required 1 deadbeef 000000 0",
                  if_done, if_rdata, stall, bus_req);
      end
      if_req = 1'b0;
      @(negedge clk);
      n_vec++;
      if (if_done !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_pulse: if_done=%b, required 0", if_done);
      end
   endtask

   task automatic test_priority();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h104;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_sel = 4'hF;
      addr_q.push_back(32'h300);
      addr_q.push_back(32'h104);
      done_q.push_back('{1'b1, 32'hA5A50001});
      done_q.push_back('{1'b0, 32'h5A5A0002});
      #1;
      n_vec++;
      if (stall !== 6'b011111) begin
         n_err++;
         $display("FAIL prio_stall: stall=%b, required 011111", stall);
      end
      serve(1, 32'hA5A50001, 6'b011111);
      n_vec++;
      if (mem_done !== 1'b1 || stall !== 6'b000011) begin
         n_err++;
         $display("FAIL prio_mem_done: mem_done=%b stall=%b, required 1 000011", mem_done, stall);
      end
      mem_req = 1'b0;
      #1;
      serve(1, 32'h5A5A0002, 6'b000011);
      n_vec++;
      if (if_done !== 1'b1 || if_rdata !== 32'h5A5A0002) begin
         n_err++;
         $display("FAIL prio_if_done: if_done=%b if_rdata=%h, required 1 5a5a0002", if_done, if_rdata);
      end
      if_req = 1'b0;
   endtask

   task automatic test_store();
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h12345678; mem_sel = 4'b0011;
      addr_q.push_back(32'h200);
      done_q.push_back('{1'b1, 32'h0});
      #1;
      @(negedge clk);
      n_vec++;
      if (bus_we !== 1'b1 || bus_wdata !== 32'h12345678 || bus_sel !== 4'b0011 || bus_addr !== 32'h200) begin
         n_err++;
         $display("FAIL store_fields: we=%b wdata=%h sel=%b addr=%h, required 1 12345678 0011 200",
                  bus_we, bus_wdata, bus_sel, bus_addr);
      end
      serve(3, 32'h0, 6'b011111);
      n_vec++;
      if (mem_done !== 1'b1 || stall !== 6'b000000) begin
         n_err++;
         $display("FAIL store_done: mem_done=%b stall=%b, required 1 000000", mem_done, stall);
      end
      mem_req = 1'b0; mem_we = 1'b0;
      @(negedge clk);
      n_vec++;
      if (mem_done !== 1'b0) begin
         n_err++;
         $display("FAIL store_pulse: mem_done=%b, required 0", mem_done);
      end
   endtask

   task automatic test_timeout();
      int hi;
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400; mem_sel = 4'hF;
      addr_q.push_back(32'h400);
      done_q.push_back('{1'b1, 32'hCAFE0001});
      #1;
      serve(4, 32'hCAFE0001, 6'b011111);
      n_vec++;
      if (mem_done !== 1'b1 || bus_err !== 1'b0) begin
         n_err++;
         $display("FAIL ack_on_limit: mem_done=%b bus_err=%b, required 1 0", mem_done, bus_err);
      end
      mem_req = 1'b0;
      @(negedge clk);
      mem_req = 1'b1; mem_addr = 32'h404;
      addr_q.push_back(32'h404);
      done_q.push_back('{1'b1, 32'h0});
      hi = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus_req === 1'b1)
            hi++;
         else if (hi > 0)
            break;
      end
      n_vec++;
      if (hi != 4 || bus_err !== 1'b1 || mem_done !== 1'b1 || mem_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL timeout_abort: req_cycles=%0d bus_err=%b mem_done=%b mem_rdata=%h, required 4 1 1 0",
                  hi, bus_err, mem_done, mem_rdata);
      end
      mem_req = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus_err !== 1'b0 || bus_req !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_idle: bus_err=%b bus_req=%b, required 0 0", bus_err, bus_req);
      end
   endtask

   task automatic test_stall_merge();
      @(negedge clk);
      stallreq_id = 1'b1;
      #1;
      n_vec++;
      if (stall !== 6'b000111) begin
         n_err++;
         $display("FAIL stall_id: stall=%b, required 000111", stall);
      end
      stallreq_ex = 1'b1;
      #1;
      n_vec++;
      if (stall !== 6'b001111) begin
         n_err++;
         $display("FAIL stall_ex: stall=%b, required 001111", stall);
      end
      mem_req = 1'b1; mem_addr = 32'h600; mem_sel = 4'hF;
      addr_q.push_back(32'h600);
      done_q.push_back('{1'b1, 32'h0BADF00D});
      #1;
      n_vec++;
      if (stall !== 6'b011111) begin
         n_err++;
         $display("FAIL stall_mem: stall=%b, required 011111", stall);
      end
      serve(1, 32'h0BADF00D, 6'b011111);
      n_vec++;
      if (stall !== 6'b001111) begin
         n_err++;
         $display("FAIL stall_mem_release: stall=%b, required 001111", stall);
      end
      mem_req = 1'b0; stallreq_ex = 1'b0;
      #1;
      n_vec++;
      if (stall !== 6'b000111) begin
         n_err++;
         $display("FAIL stall_id_only: stall=%b, required 000111", stall);
      end
      stallreq_id = 1'b0;
      #1;
      n_vec++;
      if (stall !== 6'b000000) begin
         n_err++;
         $display("FAIL stall_none: stall=%b, required 000000", stall);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      mem_req = 1'b1; mem_addr = 32'h500; mem_sel = 4'hF;
      addr_q.push_back(32'h500);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (bus_req !== 1'b0 || bus_addr !== 32'h0 || bus_sel !== 4'h0 || mem_done !== 1'b0 ||
          bus_err !== 1'b0 || mem_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_async: bus_req=%b addr=%h sel=%h mem_done=%b bus_err=%b mem_rdata=%h, required all 0",
                  bus_req, bus_addr, bus_sel, mem_done, bus_err, mem_rdata);
      end
      mem_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bus_ack = 1'b1; bus_rdata = 32'h55;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = 32'h0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_vec++;
         if (mem_done !== 1'b0 || bus_req !== 1'b0 || mem_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL late_ack: mem_done=%b bus_req=%b mem_rdata=%h, required 0 0 0",
                     mem_done, bus_req, mem_rdata);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_store();
      test_timeout();
      test_stall_merge();
      test_reset_mid();
      repeat (2) @(negedge clk);
      n_vec++;
      if (done_q.size() != 0 || addr_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: done_q=%0d addr_q=%0d left, required 0 0", done_q.size(), addr_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
